pe_feeder: RTL and testbench
============================

// Module: pe_feeder
// PURPOSE
//  Upstream operand feeder for one systolic PE. Holds host-loaded A and B operand
//  vectors in local register buffers. Issues the PE start pulse and streams (a,b)
//  pairs into the PE input FIFOs, stalling on full flags. Captures the PE's
//  accumulated result and saturation flag when the PE signals finish (fout).
// PARAMETERS
//  DW    16     operand/result width, signed two's complement
//  AW    4      buffer address width; DEPTH = 2**AW elements per vector
//  CW    8      width of len and pe_max_cntr
//  TMO   255    max cycles spent in WAIT for pe_fout before error abort
// PORTS
//  clk          in   1    clock; all state updates on rising edge
//  rst          in   1    synchronous reset, active-high
//  ld_we        in   1    buffer write strobe (ignored while busy)
//  ld_sel       in   1    0 = A buffer, 1 = B buffer
//  ld_addr      in   AW   buffer element index
//  ld_data      in   DW   element value
//  len          in   CW   vector length for this run, sampled on go
//  go           in   1    start-of-run request (ignored while busy)
//  busy         out  1    high from accepted go until return to IDLE
//  done         out  1    one-cycle pulse, result valid
//  err          out  1    one-cycle pulse: bad len or WAIT timeout
//  result       out  DW   captured pe_s_out, held until next capture
//  result_sat   out  1    captured pe_sat
//  pe_start     out  1    one-cycle start pulse to PE
//  pe_max_cntr  out  CW   latched len, held stable for whole run
//  pe_a, pe_b   out  DW   operand data to PE
//  pe_awe,pe_bwe out 1    PE FIFO write enables (always equal)
//  pe_aff,pe_bff in  1    PE FIFO full flags
//  pe_fout      in   1    PE finished, pe_s_out/pe_sat valid this cycle
//  pe_s_out     in   DW   PE result
//  pe_sat       in   1    PE saturation flag
// BEHAVIOUR
//  Reset: state IDLE; busy, done, err, pe_start, pe_awe/bwe = 0; result = 0,
//   result_sat = 0, pe_max_cntr = 0, idx = 0. Buffer contents are NOT reset.
//   Reset mid-run aborts immediately; no done/err pulse is produced.
//  IDLE: ld_we writes buf[ld_sel][ld_addr] <= ld_data. On go:
//   len == 0 or len > DEPTH -> err pulse next cycle, stay IDLE;
//   otherwise latch pe_max_cntr <= len, idx <= 0 -> START. go and ld_we in the
//   same cycle: the write completes, then the run starts.
//  START (1 cycle): pe_start = 1 -> FEED.
//  FEED: pe_awe = pe_bwe = ~(pe_aff | pe_bff) (combinational).
//   pe_a = bufA[idx], pe_b = bufB[idx] (combinational mux). On an accepted write,
//   idx++. The write at idx == len-1 goes to WAIT. Either full flag stalls both
//   FIFOs; A and B are never written separately.
//  WAIT: cycle counter tcnt++. When pe_fout = 1, capture result <= pe_s_out,
//   result_sat <= pe_sat -> DONE. pe_fout before WAIT is ignored.
//   When tcnt == TMO without pe_fout: err pulse -> IDLE.
//  DONE (1 cycle): done = 1 -> IDLE.
//  busy = (state != IDLE). pe_a/pe_b are don't-care outside FEED; drive 0.
//  Latency: go at edge n -> pe_start high in cycle n+1; first pe_awe in n+2.
//   With no stalls, the last write is in cycle n+1+len.
// STRUCTURE
//  pe_pkg: state enum {IDLE,START,FEED,WAIT,DONE}, default DW/AW/CW.
//  Sub-module pe_opbuf (DEPTH x DW register file, 1 write port, 1 comb read
//   port), instantiated twice (A, B). FSM, idx/tcnt counters and result
//   capture stay in pe_feeder.
// TESTING
//  1 load A={1,2,3,4}, B={5,6,7,8}, len=4, go; PE model -> 4 writes in order
//    (1,5)..(4,8), pe_max_cntr=4; fout with s_out=70 -> result=70, done pulse.
//  2 same run, hold pe_bff=1 for 3 cycles mid-FEED -> no awe/bwe while full;
//    no element lost or repeated; idx resumes correctly.
//  3 len=0, then len=17 -> err pulse each; pe_start never asserted; busy stays 0.
//  4 PE model returns s_out=16'h7FFF, sat=1 -> result=7FFF, result_sat=1.
//  5 rst=1 during FEED after 2 writes -> next cycle IDLE, all outputs 0;
//    new go replays from idx 0 using the retained buffer contents.
//  6 never assert pe_fout -> err exactly TMO cycles after entering WAIT; busy drops.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and default sizes for the systolic PE operand feeder.
package pe_pkg;

    localparam int unsigned DW_DEF  = 16;   // operand / result width
    localparam int unsigned AW_DEF  = 4;    // buffer address width
    localparam int unsigned CW_DEF  = 8;    // run-length width
    localparam int unsigned TMO_DEF = 255;  // WAIT timeout in cycles

    typedef enum logic [2:0] {
        IDLE,
        START,
        FEED,
        WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/pe_opbuf.sv
// Operand vector buffer: DEPTH x DW register file, one write port, one
// combinational read port. Contents are deliberately not reset.
//   clk_i      clock
//   we_i       write strobe
//   waddr_i    write element index
//   wdata_i    write data
//   raddr_i    read element index
//   rdata_c_o  read data (combinational)
module pe_opbuf #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_c_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/pe_feeder.sv
// Upstream operand feeder for one systolic PE. Buffers host-loaded A/B
// vectors, pulses the PE start, streams (a,b) pairs into the PE FIFOs while
// honouring their full flags, and captures the PE result on pe_fout.
//   clk_i, rst_i          clock, synchronous active-high reset
//   ld_*_i                host buffer load port (ignored while busy)
//   len_i, go_i           run length and start request
//   busy_o, done_o, err_o run status (done/err are one-cycle pulses)
//   result_o, result_sat_o captured PE result and saturation flag
//   pe_start_o            one-cycle start pulse to the PE
//   pe_max_cntr_o         latched run length
//   pe_a_c_o, pe_b_c_o    operand data (combinational, 0 outside FEED)
//   pe_awe_c_o, pe_bwe_c_o PE FIFO write enables (combinational, always equal)
//   pe_aff_i, pe_bff_i    PE FIFO full flags
//   pe_fout_i, pe_s_out_i, pe_sat_i  PE completion and result
module pe_feeder
    import pe_pkg::*;
#(
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned AW  = AW_DEF,
    parameter int unsigned CW  = CW_DEF,
    parameter int unsigned TMO = TMO_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ld_we_i,
    input  logic          ld_sel_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [DW-1:0] ld_data_i,
    input  logic [CW-1:0] len_i,
    input  logic          go_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [DW-1:0] result_o,
    output logic          result_sat_o,
    output logic          pe_start_o,
    output logic [CW-1:0] pe_max_cntr_o,
    output logic [DW-1:0] pe_a_c_o,
    output logic [DW-1:0] pe_b_c_o,
    output logic          pe_awe_c_o,
    output logic          pe_bwe_c_o,
    input  logic          pe_aff_i,
    input  logic          pe_bff_i,
    input  logic          pe_fout_i,
    input  logic [DW-1:0] pe_s_out_i,
    input  logic          pe_sat_i
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned TW    = $clog2(TMO + 1);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [CW-1:0] max_cntr_q, max_cntr_d;
    logic [DW-1:0] result_q, result_d;
    logic          result_sat_q, result_sat_d;
    logic          err_d;
    logic          busy_q, done_q, err_q, pe_start_q;

    logic          idle_c, len_bad_c, accept_c, last_c, timeout_c;
    logic [DW-1:0] a_rd_c, b_rd_c;

    assign idle_c    = (state_q == IDLE);
    assign len_bad_c = (len_i == '0) || (32'(len_i) > DEPTH);
    // Both FIFOs are written together, so either full flag stalls the pair.
    assign accept_c  = (state_q == FEED) && !(pe_aff_i || pe_bff_i);
    assign last_c    = ((CW'(idx_q) + CW'(1)) == max_cntr_q);
    assign timeout_c = ((tcnt_q + TW'(1)) == TW'(TMO));

    // Host loads only land while idle; a load coincident with go still lands.
    pe_opbuf #(.DW(DW), .AW(AW)) u_buf_a (
        .clk_i     (clk_i),
        .we_i      (ld_we_i && idle_c && !ld_sel_i),
        .waddr_i   (ld_addr_i),
        .wdata_i   (ld_data_i),
        .raddr_i   (idx_q),
        .rdata_c_o (a_rd_c)
    );

    pe_opbuf #(.DW(DW), .AW(AW)) u_buf_b (
        .clk_i     (clk_i),
        .we_i      (ld_we_i && idle_c && ld_sel_i),
        .waddr_i   (ld_addr_i),
        .wdata_i   (ld_data_i),
        .raddr_i   (idx_q),
        .rdata_c_o (b_rd_c)
    );

    // Next-state, counters and result capture.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tcnt_d       = tcnt_q;
        max_cntr_d   = max_cntr_q;
        result_d     = result_q;
        result_sat_d = result_sat_q;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (go_i) begin
                    if (len_bad_c) begin
                        err_d = 1'b1;
                    end else begin
                        max_cntr_d = len_i;
                        idx_d      = '0;
                        state_d    = START;
                    end
                end
            end
            START: begin
                state_d = FEED;
            end
            FEED: begin
                if (accept_c) begin
                    idx_d = idx_q + AW'(1);
                    if (last_c) begin
                        tcnt_d  = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (pe_fout_i) begin
                    result_d     = pe_s_out_i;
                    result_sat_d = pe_sat_i;
                    state_d      = DONE;
                end else if (timeout_c) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags decode the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            tcnt_q       <= '0;
            max_cntr_q   <= '0;
            result_q     <= '0;
            result_sat_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            pe_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tcnt_q       <= tcnt_d;
            max_cntr_q   <= max_cntr_d;
            result_q     <= result_d;
            result_sat_q <= result_sat_d;
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
            err_q        <= err_d;
            pe_start_q   <= (state_d == START);
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign result_o      = result_q;
    assign result_sat_o  = result_sat_q;
    assign pe_start_o    = pe_start_q;
    assign pe_max_cntr_o = max_cntr_q;
    assign pe_awe_c_o    = accept_c;
    assign pe_bwe_c_o    = accept_c;
    assign pe_a_c_o      = (state_q == FEED) ? a_rd_c : '0;
    assign pe_b_c_o      = (state_q == FEED) ? b_rd_c : '0;

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: vector table, hand-written reset
// sequence, then randomized runs against a behavioural model.
module tb_pe_feeder;

    localparam int DEPTH  = 16;
    localparam int TMO    = 255;
    localparam int BUDGET = 2000;

    logic        clk, rst;
    logic        ld_we, ld_sel;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic [7:0]  len;
    logic        go;
    logic        busy, done, err;
    logic [15:0] result;
    logic        result_sat, pe_start;
    logic [7:0]  pe_max_cntr;
    logic [15:0] pe_a, pe_b;
    logic        pe_awe, pe_bwe;
    logic        pe_aff, pe_bff, pe_fout, pe_sat;
    logic [15:0] pe_s_out;

    pe_feeder dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ld_we_i       (ld_we),
        .ld_sel_i      (ld_sel),
        .ld_addr_i     (ld_addr),
        .ld_data_i     (ld_data),
        .len_i         (len),
        .go_i          (go),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .result_o      (result),
        .result_sat_o  (result_sat),
        .pe_start_o    (pe_start),
        .pe_max_cntr_o (pe_max_cntr),
        .pe_a_c_o      (pe_a),
        .pe_b_c_o      (pe_b),
        .pe_awe_c_o    (pe_awe),
        .pe_bwe_c_o    (pe_bwe),
        .pe_aff_i      (pe_aff),
        .pe_bff_i      (pe_bff),
        .pe_fout_i     (pe_fout),
        .pe_s_out_i    (pe_s_out),
        .pe_sat_i      (pe_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference copy of the operand buffers.
    logic [15:0] ma [DEPTH];
    logic [15:0] mb [DEPTH];

    // len, stall_pct, win_start, win_len, fout_dly, sout, sat, fout_en, go_wr, exp_err
    typedef struct {
        int          len;
        int          stall_pct;
        int          win_start;
        int          win_len;
        int          fout_dly;
        logic [15:0] sout;
        logic        sat;
        bit          fout_en;
        bit          go_wr;
        bit          exp_err;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        go = 1'b0; ld_we = 1'b0; pe_aff = 1'b0; pe_bff = 1'b0; pe_fout = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_start"}, 32'(pe_start), 0);
        chk({tag, "_awe"}, 32'(pe_awe), 0);
        chk({tag, "_bwe"}, 32'(pe_bwe), 0);
        chk({tag, "_a"}, 32'(pe_a), 0);
        chk({tag, "_b"}, 32'(pe_b), 0);
        chk({tag, "_result"}, 32'(result), 0);
        chk({tag, "_rsat"}, 32'(result_sat), 0);
        chk({tag, "_maxc"}, 32'(pe_max_cntr), 0);
    endtask

    task automatic load(input logic sel, input logic [3:0] addr, input logic [15:0] data);
        @(posedge clk); #1;
        idle_inputs();
        ld_we = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
        if (sel) mb[addr] = data; else ma[addr] = data;
        @(negedge clk);
    endtask

    // One complete run: go in cycle 0, then the PE side is emulated per cycle.
    task automatic run_vec(input vec_t v);
        int  writes, last_wr, exp_end;
        bit  bad, fin, feeding, exp_we;
        bad     = (v.len == 0) || (v.len > DEPTH);
        writes  = 0;
        last_wr = -1;
        exp_end = bad ? 1 : -1;
        fin     = 1'b0;
        @(posedge clk); #1;
        idle_inputs();
        go  = 1'b1;
        len = 8'(v.len);
        if (v.go_wr) begin
            ld_we = 1'b1; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 16'($urandom);
            ma[0] = ld_data;
        end
        @(negedge clk);
        chk("busy_before_go", 32'(busy), 0);
        for (int c = 1; c <= BUDGET && !fin; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            pe_s_out = 16'($urandom);
            pe_sat   = 1'($urandom);
            feeding  = !bad && (writes < v.len);
            if (feeding) begin
                // Junk host writes must not land while busy; stray fout is ignored.
                ld_we   = ($urandom_range(0, 3) == 0);
                ld_sel  = 1'($urandom);
                ld_addr = 4'($urandom);
                ld_data = 16'($urandom);
                pe_fout = ($urandom_range(0, 7) == 0);
                if (c >= v.win_start && c < v.win_start + v.win_len) pe_bff = 1'b1;
                if (v.stall_pct > 0 && $urandom_range(0, 99) < v.stall_pct) begin
                    if ($urandom_range(0, 1) == 0) pe_aff = 1'b1; else pe_bff = 1'b1;
                end
            end else if (!bad && v.fout_en && (c - last_wr == v.fout_dly)) begin
                pe_fout  = 1'b1;
                pe_s_out = v.sout;
                pe_sat   = v.sat;
                exp_end  = c + 1;
            end
            if (!bad && !v.fout_en && writes == v.len) exp_end = last_wr + 1 + TMO;
            @(negedge clk);
            chk("pe_start", 32'(pe_start), 32'(!bad && c == 1));
            if (c == 1) begin
                chk("busy_after_go", 32'(busy), 32'(!bad));
                if (!bad) chk("max_cntr", 32'(pe_max_cntr), 32'(v.len));
            end
            exp_we = feeding && (c >= 2) && !(pe_aff || pe_bff);
            chk("awe", 32'(pe_awe), 32'(exp_we));
            chk("bwe", 32'(pe_bwe), 32'(exp_we));
            if (pe_awe && writes < v.len) begin
                chk("pe_a", 32'(pe_a), 32'(ma[writes]));
                chk("pe_b", 32'(pe_b), 32'(mb[writes]));
                writes++;
                last_wr = c;
            end
            chk("done", 32'(done), 32'(c == exp_end && !v.exp_err));
            chk("err", 32'(err), 32'(c == exp_end && v.exp_err));
            if (c == exp_end && !v.exp_err) begin
                chk("result", 32'(result), 32'(v.sout));
                chk("result_sat", 32'(result_sat), 32'(v.sat));
                chk("busy_in_done", 32'(busy), 1);
            end
            if (c == exp_end) fin = 1'b1;
        end
        if (!fin) chk("run_bound", 0, 1);
        if (!bad) chk("write_count", 32'(writes), 32'(v.len));
        if (!bad && v.stall_pct == 0 && v.win_len == 0)
            chk("last_write_cycle", 32'(last_wr), 32'(1 + v.len));
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("busy_after_run", 32'(busy), 0);
        chk("start_after_run", 32'(pe_start), 0);
    endtask

    initial begin
        vec_t rv;
        tbl[0] = '{4,  0,  0, 0, 2, 16'd70,    1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{4,  0,  4, 3, 1, 16'd70,    1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{0,  0,  0, 0, 1, 16'd0,     1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{17, 0,  0, 0, 1, 16'd0,     1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{4,  0,  0, 0, 3, 16'h7FFF,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{16, 30, 0, 0, 4, 16'h8001,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1,  0,  0, 0, 1, 16'hBEEF,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{3,  0,  0, 0, 1, 16'd0,     1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = '0; len = '0;
        pe_s_out = '0; pe_sat = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            load(1'b0, 4'(i), 16'($urandom));
            load(1'b1, 4'(i), 16'($urandom));
        end
        for (int i = 0; i < 4; i++) begin
            load(1'b0, 4'(i), 16'(i + 1));
            load(1'b1, 4'(i), 16'(i + 5));
        end

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Reset in FEED after two writes, then replay from the retained buffers.
        @(posedge clk); #1;
        idle_inputs(); go = 1'b1; len = 8'd4;
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
        end
        chk("rst_seq_write2", 32'({pe_awe, pe_a}), 32'({1'b1, ma[1]}));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midrun_rst");
        run_vec(tbl[0]);

        // Randomized runs against the model.
        for (int k = 0; k < 25; k++) begin
            for (int j = 0; j < int'($urandom_range(0, 4)); j++)
                load(1'($urandom), 4'($urandom), 16'($urandom));
            rv.len       = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 40)) * int'($urandom_range(0, 1))
                                                       : int'($urandom_range(1, 16));
            rv.stall_pct = int'($urandom_range(0, 40));
            rv.win_start = 0;
            rv.win_len   = 0;
            rv.fout_dly  = int'($urandom_range(1, 6));
            rv.sout      = 16'($urandom);
            rv.sat       = 1'($urandom);
            rv.fout_en   = 1'b1;
            rv.go_wr     = 1'($urandom);
            rv.exp_err   = (rv.len == 0) || (rv.len > DEPTH);
            run_vec(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
